start_screen_sequencer: RTL and testbench

Frame-driven controller for the start screen. It decides which start-screen layers (start text, "space invaders" title, credit text, names) are enabled, blinks the credit layer, scrolls the names layer, and counts coin credits. It hands control to the game with a one-cycle start pulse. Its outputs gate the four drawing-request producers that feed the start-screen priority mux, and it receives game-over back from the game logic.

---
 rtl/start_screen_pkg.sv | 34 +++
 rtl/key_edge_detect.sv | 25 ++
 rtl/start_screen_sequencer.sv | 158 +++++++++++++++
 tb/tb_start_screen_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/start_screen_pkg.sv
// rtl/start_screen_pkg.sv - shared state type, default frame constants and credit helper
package start_screen_pkg;

    typedef enum logic [2:0] {
        REVEAL,
        ATTRACT,
        START,
        IN_GAME,
        OVER_HOLD
    } sequencer_state_t;

    localparam int DEF_REVEAL_FRAMES = 60;
    localparam int DEF_BLINK_FRAMES  = 30;
    localparam int DEF_SCROLL_STEP   = 1;
    localparam int DEF_SCROLL_MAX    = 479;
    localparam int DEF_MAX_CREDITS   = 9;
    localparam int DEF_OVER_FRAMES   = 180;

    // Wide enough for any of the frame-count constants above.
    localparam int FRAME_CNT_W = 16;

    // Add one coin to the credit count, holding at the saturation limit.
    function automatic logic [3:0] credit_add(
        input logic [3:0] count,
        input logic       coin,
        input logic [3:0] limit
    );
        if (coin && (count < limit)) begin
            return count + 4'd1;
        end
        return count;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - key synchroniser with registered rising-edge pulse
module key_edge_detect (
    input  logic clk,
    input  logic resetN,
    input  logic key,
    output logic rise
);

    logic sampled;
    logic previous;

    // Sample the key once, keep its history, and register a one-cycle pulse on 0->1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sampled  <= 1'b0;
            previous <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sampled  <= key;
            previous <= sampled;
            rise     <= sampled & ~previous;
        end
    end

endmodule

// File: rtl/start_screen_sequencer.sv
// rtl/start_screen_sequencer.sv - start-screen layer sequencing, credits and game hand-off
module start_screen_sequencer
    import start_screen_pkg::*;
#(
    parameter int REVEAL_FRAMES = DEF_REVEAL_FRAMES,
    parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
    parameter int SCROLL_STEP   = DEF_SCROLL_STEP,
    parameter int SCROLL_MAX    = DEF_SCROLL_MAX,
    parameter int MAX_CREDITS   = DEF_MAX_CREDITS,
    parameter int OVER_FRAMES   = DEF_OVER_FRAMES
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       coinKey,
    input  logic       startKey,
    input  logic       gameOver,
    output logic       startEnable,
    output logic       spaceEnable,
    output logic       creditEnable,
    output logic       namesEnable,
    output logic [8:0] namesOffsetY,
    output logic [3:0] credits,
    output logic       gameStartPulse,
    output logic       showStartScreen
);

    localparam int CW = FRAME_CNT_W;

    logic             coin_rise;
    logic             start_rise;

    sequencer_state_t state;
    sequencer_state_t state_nxt;
    logic [CW-1:0]    frame_cnt;
    logic [CW-1:0]    frame_cnt_nxt;
    logic             blink;
    logic             blink_nxt;
    logic [8:0]       offset_nxt;
    logic [9:0]       offset_sum;
    logic [3:0]       credits_coin;
    logic [3:0]       credits_nxt;

    key_edge_detect u_coin_edge (
        .clk    (clk),
        .resetN (resetN),
        .key    (coinKey),
        .rise   (coin_rise)
    );

    key_edge_detect u_start_edge (
        .clk    (clk),
        .resetN (resetN),
        .key    (startKey),
        .rise   (start_rise)
    );

    // Credit count after this cycle's coin, and the next scroll position before wrapping.
    always_comb begin
        credits_coin = credit_add(credits, coin_rise, 4'(MAX_CREDITS));
        offset_sum   = {1'b0, namesOffsetY} + 10'(SCROLL_STEP);
    end

    // Next-state logic; a frame pulse that causes a transition is not counted by the new state.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        blink_nxt     = blink;
        offset_nxt    = namesOffsetY;
        credits_nxt   = (state == IN_GAME) ? credits : credits_coin;

        case (state)
            REVEAL: begin
                if (startOfFrame) begin
                    if (frame_cnt == CW'(REVEAL_FRAMES - 1)) begin
                        state_nxt     = ATTRACT;
                        frame_cnt_nxt = '0;
                        blink_nxt     = 1'b1;
                        offset_nxt    = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            ATTRACT: begin
                // The coin in this same cycle already counts toward the start decision.
                if (start_rise && (credits_coin != 4'd0)) begin
                    state_nxt   = START;
                    credits_nxt = credits_coin - 4'd1;
                end else if (startOfFrame) begin
                    offset_nxt = (offset_sum > 10'(SCROLL_MAX)) ? 9'd0 : offset_sum[8:0];
                    if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                        frame_cnt_nxt = '0;
                        blink_nxt     = ~blink;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            START: begin
                state_nxt = IN_GAME;
            end
            IN_GAME: begin
                if (gameOver) begin
                    state_nxt     = OVER_HOLD;
                    frame_cnt_nxt = '0;
                end
            end
            OVER_HOLD: begin
                if (startOfFrame) begin
                    if (frame_cnt == CW'(OVER_FRAMES - 1)) begin
                        state_nxt     = ATTRACT;
                        frame_cnt_nxt = '0;
                        blink_nxt     = 1'b1;
                        offset_nxt    = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt     = REVEAL;
                frame_cnt_nxt = '0;
            end
        endcase
    end

    // State, counters and registered layer controls, all decoded from the next state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= REVEAL;
            frame_cnt       <= '0;
            blink           <= 1'b1;
            namesOffsetY    <= '0;
            credits         <= '0;
            startEnable     <= 1'b0;
            spaceEnable     <= 1'b0;
            creditEnable    <= 1'b0;
            namesEnable     <= 1'b0;
            gameStartPulse  <= 1'b0;
            showStartScreen <= 1'b1;
        end else begin
            state           <= state_nxt;
            frame_cnt       <= frame_cnt_nxt;
            blink           <= blink_nxt;
            namesOffsetY    <= offset_nxt;
            credits         <= credits_nxt;
            startEnable     <= (state_nxt == REVEAL) || (state_nxt == ATTRACT) ||
                               (state_nxt == OVER_HOLD);
            spaceEnable     <= (state_nxt == ATTRACT);
            namesEnable     <= (state_nxt == ATTRACT);
            creditEnable    <= (state_nxt == ATTRACT) && blink_nxt;
            gameStartPulse  <= (state_nxt == START);
            showStartScreen <= (state_nxt != IN_GAME);
        end
    end

endmodule

// File: tb/tb_start_screen_sequencer.sv
// tb/tb_start_screen_sequencer.sv - directed vector table, corner sequences and random run against a reference model
module tb_start_screen_sequencer;

    localparam int REVEAL_FRAMES = 60;
    localparam int BLINK_FRAMES  = 30;
    localparam int SCROLL_STEP   = 1;
    localparam int SCROLL_MAX    = 479;
    localparam int MAX_CREDITS   = 9;
    localparam int OVER_FRAMES   = 180;

    localparam int M_REV   = 0;
    localparam int M_ATT   = 1;
    localparam int M_START = 2;
    localparam int M_GAME  = 3;
    localparam int M_OVER  = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       coinKey;
    logic       startKey;
    logic       gameOver;
    logic       startEnable;
    logic       spaceEnable;
    logic       creditEnable;
    logic       namesEnable;
    logic [8:0] namesOffsetY;
    logic [3:0] credits;
    logic       gameStartPulse;
    logic       showStartScreen;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    int m_mode, m_rf, m_af, m_of, m_cred, m_off;
    bit h_c[3];
    bit h_s[3];

    typedef struct {
        int         frames;
        int         coins;
        int         hold;
        bit         start;
        bit         gover;
        logic [3:0] credits;
        logic       se, sp, ce, ne, show;
        logic [8:0] off;
        int         pulses;
    } vec_t;

    vec_t vecs[$];

    start_screen_sequencer dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .coinKey         (coinKey),
        .startKey        (startKey),
        .gameOver        (gameOver),
        .startEnable     (startEnable),
        .spaceEnable     (spaceEnable),
        .creditEnable    (creditEnable),
        .namesEnable     (namesEnable),
        .namesOffsetY    (namesOffsetY),
        .credits         (credits),
        .gameStartPulse  (gameStartPulse),
        .showStartScreen (showStartScreen)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gameStartPulse === 1'b1) pulse_cnt++;
    end

    function automatic logic [31:0] pack(input logic se, input logic sp, input logic ce,
                                         input logic ne, input logic show, input logic pulse,
                                         input logic [3:0] cr, input logic [8:0] off);
        return {13'd0, se, sp, ce, ne, show, pulse, cr, off};
    endfunction

    function automatic logic [31:0] dut_outs();
        return pack(startEnable, spaceEnable, creditEnable, namesEnable, showStartScreen,
                    gameStartPulse, credits, namesOffsetY);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_mode = M_REV; m_rf = 0; m_af = 0; m_of = 0; m_cred = 0; m_off = 0;
        for (int i = 0; i < 3; i++) begin
            h_c[i] = 1'b0;
            h_s[i] = 1'b0;
        end
    endtask

    // One clock edge of the model: key events are seen two edges after the pin is sampled.
    task automatic model_step(input bit c, input bit s, input bit f, input bit g);
        bit ce, se;
        ce = h_c[1] && !h_c[2];
        se = h_s[1] && !h_s[2];
        h_c[2] = h_c[1]; h_c[1] = h_c[0]; h_c[0] = c;
        h_s[2] = h_s[1]; h_s[1] = h_s[0]; h_s[0] = s;
        if (m_mode != M_GAME && ce) m_cred = (m_cred + 1 > MAX_CREDITS) ? MAX_CREDITS : m_cred + 1;
        case (m_mode)
            M_REV: if (f) begin
                m_rf++;
                if (m_rf == REVEAL_FRAMES) begin m_mode = M_ATT; m_af = 0; m_off = 0; end
            end
            M_ATT: begin
                if (se && m_cred > 0) begin
                    m_mode = M_START;
                    m_cred--;
                end else if (f) begin
                    m_af++;
                    m_off = (m_af * SCROLL_STEP) % (SCROLL_MAX + 1);
                end
            end
            M_START: m_mode = M_GAME;
            M_GAME: if (g) begin m_mode = M_OVER; m_of = 0; end
            default: if (f) begin
                m_of++;
                if (m_of == OVER_FRAMES) begin m_mode = M_ATT; m_af = 0; m_off = 0; end
            end
        endcase
    endtask

    function automatic logic [31:0] model_outs();
        logic blink;
        blink = ((m_af / BLINK_FRAMES) % 2) == 0;
        return pack(m_mode == M_REV || m_mode == M_ATT || m_mode == M_OVER,
                    m_mode == M_ATT, m_mode == M_ATT && blink, m_mode == M_ATT,
                    m_mode != M_GAME, m_mode == M_START, 4'(m_cred), 9'(m_off));
    endfunction

    initial begin
        int pc;
        resetN = 1'b0; startOfFrame = 1'b0; coinKey = 1'b0; startKey = 1'b0; gameOver = 1'b0;

        vecs.push_back('{0,   0,  1, 0, 0, 4'd0, 1, 0, 0, 0, 1, 9'd0,  0});
        vecs.push_back('{59,  0,  1, 0, 0, 4'd0, 1, 0, 0, 0, 1, 9'd0,  0});
        vecs.push_back('{1,   0,  1, 0, 0, 4'd0, 1, 1, 1, 1, 1, 9'd0,  0});
        vecs.push_back('{29,  0,  1, 0, 0, 4'd0, 1, 1, 1, 1, 1, 9'd29, 0});
        vecs.push_back('{1,   0,  1, 0, 0, 4'd0, 1, 1, 0, 1, 1, 9'd30, 0});
        vecs.push_back('{30,  0,  1, 0, 0, 4'd0, 1, 1, 1, 1, 1, 9'd60, 0});
        vecs.push_back('{0,   0,  1, 1, 0, 4'd0, 1, 1, 1, 1, 1, 9'd60, 0});
        vecs.push_back('{0,   1, 10, 0, 0, 4'd1, 1, 1, 1, 1, 1, 9'd60, 0});
        vecs.push_back('{0,   1,  2, 0, 0, 4'd2, 1, 1, 1, 1, 1, 9'd60, 0});
        vecs.push_back('{0,   0,  1, 1, 0, 4'd1, 0, 0, 0, 0, 0, 9'd60, 1});
        vecs.push_back('{0,   3,  2, 0, 0, 4'd1, 0, 0, 0, 0, 0, 9'd60, 1});
        vecs.push_back('{179, 0,  1, 0, 1, 4'd1, 1, 0, 0, 0, 1, 9'd60, 1});
        vecs.push_back('{1,   0,  1, 0, 0, 4'd1, 1, 1, 1, 1, 1, 9'd0,  1});
        vecs.push_back('{0,  12,  3, 0, 0, 4'd9, 1, 1, 1, 1, 1, 9'd0,  1});
        vecs.push_back('{30,  0,  1, 0, 0, 4'd9, 1, 1, 0, 1, 1, 9'd30, 1});

        @(negedge clk);
        check("reset_outs", dut_outs(), pack(0, 0, 0, 0, 1, 0, 4'd0, 9'd0));
        resetN = 1'b1;

        foreach (vecs[i]) begin
            gameOver = vecs[i].gover;
            @(negedge clk);
            for (int k = 0; k < vecs[i].coins; k++) begin
                coinKey = 1'b1;
                repeat (vecs[i].hold) @(negedge clk);
                coinKey = 1'b0;
                repeat (3) @(negedge clk);
            end
            if (vecs[i].start) begin
                startKey = 1'b1;
                @(negedge clk);
                startKey = 1'b0;
                repeat (4) @(negedge clk);
            end
            for (int k = 0; k < vecs[i].frames; k++) frame();
            check($sformatf("vec%0d_outs", i), dut_outs(),
                  pack(vecs[i].se, vecs[i].sp, vecs[i].ce, vecs[i].ne, vecs[i].show, 1'b0,
                       vecs[i].credits, vecs[i].off));
            check($sformatf("vec%0d_pulses", i), pulse_cnt, vecs[i].pulses);
        end

        // Coin at saturation plus start in the same cycle: pulse exactly three cycles later.
        coinKey = 1'b1; startKey = 1'b1;
        @(negedge clk); check("lat_c1_pulse", gameStartPulse, 1'b0);
        @(negedge clk); check("lat_c2_pulse", gameStartPulse, 1'b0);
        @(negedge clk); check("lat_c3_pulse", gameStartPulse, 1'b1);
        check("sat_start_credits", credits, 4'd8);
        coinKey = 1'b0; startKey = 1'b0;
        @(negedge clk); check("lat_c4_pulse", gameStartPulse, 1'b0);
        check("lat_in_game_show", showStartScreen, 1'b0);

        // Asynchronous reset while in game.
        repeat (3) @(negedge clk);
        pc = pulse_cnt;
        resetN = 1'b0;
        #1;
        check("midgame_reset_outs", dut_outs(), pack(0, 0, 0, 0, 1, 0, 4'd0, 9'd0));
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset_outs", dut_outs(), pack(1, 0, 0, 0, 1, 0, 4'd0, 9'd0));
        check("after_reset_no_pulse", pulse_cnt, pc);

        // Coin and start together with no credits: the coin pays for the game.
        for (int k = 0; k < REVEAL_FRAMES; k++) frame();
        check("reattract_space", spaceEnable, 1'b1);
        pc = pulse_cnt;
        coinKey = 1'b1; startKey = 1'b1;
        repeat (3) @(negedge clk);
        check("zero_coin_start_pulse", gameStartPulse, 1'b1);
        check("zero_coin_start_credits", credits, 4'd0);
        coinKey = 1'b0; startKey = 1'b0;
        @(negedge clk);
        check("zero_coin_start_show", showStartScreen, 1'b0);
        check("zero_coin_start_count", pulse_cnt, pc + 1);

        // Randomised run against the reference model.
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) coinKey = ~coinKey;
            if ($urandom_range(0, 5) == 0) startKey = ~startKey;
            startOfFrame = 1'($urandom_range(0, 1));
            gameOver = ($urandom_range(0, 15) == 0);
            model_step(coinKey, startKey, startOfFrame, gameOver);
            @(negedge clk);
            check($sformatf("rand_cycle%0d", i), dut_outs(), model_outs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
